// File: rtl/tilelink_ad_arbiter.sv
// Two-master TileLink-UL A/D arbiter: round-robin grant in IDLE, one transaction
// outstanding downstream, multi-beat Put bursts on A and multi-beat responses on D.
module tilelink_ad_arbiter #(
  parameter int XLEN       = 32,
  parameter int BEAT_BYTES = XLEN / 8
) (
  input  logic                  clock,
  input  logic                  reset,
  // master 0
  input  logic                  m0_a_valid,
  output logic                  m0_a_ready,
  input  logic [2:0]            m0_a_bits_opcode,
  input  logic [2:0]            m0_a_bits_param,
  input  logic [3:0]            m0_a_bits_size,
  input  logic                  m0_a_bits_source,
  input  logic [31:0]           m0_a_bits_address,
  input  logic [BEAT_BYTES-1:0] m0_a_bits_mask,
  input  logic [XLEN-1:0]       m0_a_bits_data,
  input  logic                  m0_d_ready,
  output logic                  m0_d_valid,
  output logic [2:0]            m0_d_bits_opcode,
  output logic [1:0]            m0_d_bits_param,
  output logic [3:0]            m0_d_bits_size,
  output logic                  m0_d_bits_source,
  output logic                  m0_d_bits_sink,
  output logic [XLEN-1:0]       m0_d_bits_data,
  output logic                  m0_d_bits_error,
  // master 1
  input  logic                  m1_a_valid,
  output logic                  m1_a_ready,
  input  logic [2:0]            m1_a_bits_opcode,
  input  logic [2:0]            m1_a_bits_param,
  input  logic [3:0]            m1_a_bits_size,
  input  logic                  m1_a_bits_source,
  input  logic [31:0]           m1_a_bits_address,
  input  logic [BEAT_BYTES-1:0] m1_a_bits_mask,
  input  logic [XLEN-1:0]       m1_a_bits_data,
  input  logic                  m1_d_ready,
  output logic                  m1_d_valid,
  output logic [2:0]            m1_d_bits_opcode,
  output logic [1:0]            m1_d_bits_param,
  output logic [3:0]            m1_d_bits_size,
  output logic                  m1_d_bits_source,
  output logic                  m1_d_bits_sink,
  output logic [XLEN-1:0]       m1_d_bits_data,
  output logic                  m1_d_bits_error,
  // shared downstream
  output logic                  s_a_valid,
  input  logic                  s_a_ready,
  output logic [2:0]            s_a_bits_opcode,
  output logic [2:0]            s_a_bits_param,
  output logic [3:0]            s_a_bits_size,
  output logic                  s_a_bits_source,
  output logic [31:0]           s_a_bits_address,
  output logic [BEAT_BYTES-1:0] s_a_bits_mask,
  output logic [XLEN-1:0]       s_a_bits_data,
  input  logic                  s_d_valid,
  output logic                  s_d_ready,
  input  logic [2:0]            s_d_bits_opcode,
  input  logic [1:0]            s_d_bits_param,
  input  logic [3:0]            s_d_bits_size,
  input  logic                  s_d_bits_source,
  input  logic                  s_d_bits_sink,
  input  logic [XLEN-1:0]       s_d_bits_data,
  input  logic                  s_d_bits_error,
  // status
  output logic                  busy,
  output logic                  owner
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] A_BURST = 2'd1;
  localparam logic [1:0] D_WAIT  = 2'd2;

  // Beats spanned by a 2^size transfer; sizes above 8 saturate rather than wrap.
  function automatic logic [8:0] span_beats(input logic [3:0] size);
    logic [3:0] sz;
    logic [9:0] n;
    sz = (size > 4'd8) ? 4'd8 : size;
    n  = (10'd1 << sz) / 10'(BEAT_BYTES);
    return (n == 10'd0) ? 9'd1 : n[8:0];
  endfunction

  // Only PutFull/PutPartial carry data on A.
  function automatic logic [8:0] a_beats(input logic [2:0] op, input logic [3:0] size);
    return (op == 3'd0 || op == 3'd1) ? span_beats(size) : 9'd1;
  endfunction

  // Get, Arithmetic and Logical return data on D.
  function automatic logic [8:0] d_beats(input logic [2:0] op, input logic [3:0] size);
    return (op == 3'd2 || op == 3'd3 || op == 3'd4) ? span_beats(size) : 9'd1;
  endfunction

  logic [1:0] state_q, state_d;
  logic       last_grant_q, last_grant_d;
  logic       owner_q, owner_d;
  logic [2:0] opcode_q, opcode_d;
  logic [3:0] size_q, size_d;
  logic       src_q, src_d;
  logic [8:0] a_cnt_q, a_cnt_d;
  logic [8:0] d_cnt_q, d_cnt_d;

  logic winner, sel, sel_valid, sel_src, a_fire, d_fire;

  // Round-robin pick: on a tie the master that did not win last time gets the grant.
  always_comb begin
    if (m0_a_valid && m1_a_valid) winner = ~last_grant_q;
    else                          winner = m1_a_valid;
  end

  assign sel = (state_q == IDLE) ? winner : owner_q;

  // A-channel mux; downstream source is the master index, not the master's own source.
  always_comb begin
    if (sel) begin
      s_a_bits_opcode  = m1_a_bits_opcode;
      s_a_bits_param   = m1_a_bits_param;
      s_a_bits_size    = m1_a_bits_size;
      s_a_bits_address = m1_a_bits_address;
      s_a_bits_mask    = m1_a_bits_mask;
      s_a_bits_data    = m1_a_bits_data;
      sel_valid        = m1_a_valid;
      sel_src          = m1_a_bits_source;
    end else begin
      s_a_bits_opcode  = m0_a_bits_opcode;
      s_a_bits_param   = m0_a_bits_param;
      s_a_bits_size    = m0_a_bits_size;
      s_a_bits_address = m0_a_bits_address;
      s_a_bits_mask    = m0_a_bits_mask;
      s_a_bits_data    = m0_a_bits_data;
      sel_valid        = m0_a_valid;
      sel_src          = m0_a_bits_source;
    end
    s_a_bits_source = sel;
    s_a_valid       = 1'b0;
    m0_a_ready      = 1'b0;
    m1_a_ready      = 1'b0;
    // Handshakes are gated by reset so nothing leaks out while it is held low.
    if (reset && (state_q == IDLE || state_q == A_BURST)) begin
      s_a_valid  = sel_valid;
      m0_a_ready = ~sel & sel_valid & s_a_ready;
      m1_a_ready = sel & sel_valid & s_a_ready;
    end
  end

  // D-channel routing to the owner; stray downstream beats outside D_WAIT are dropped.
  always_comb begin
    s_d_ready  = 1'b0;
    m0_d_valid = 1'b0;
    m1_d_valid = 1'b0;
    if (state_q == D_WAIT) begin
      s_d_ready  = owner_q ? m1_d_ready : m0_d_ready;
      m0_d_valid = ~owner_q & s_d_valid;
      m1_d_valid = owner_q & s_d_valid;
    end
  end

  assign m0_d_bits_opcode = s_d_bits_opcode;
  assign m0_d_bits_param  = s_d_bits_param;
  assign m0_d_bits_size   = s_d_bits_size;
  assign m0_d_bits_source = src_q;
  assign m0_d_bits_sink   = s_d_bits_sink;
  assign m0_d_bits_data   = s_d_bits_data;
  assign m0_d_bits_error  = s_d_bits_error;
  assign m1_d_bits_opcode = s_d_bits_opcode;
  assign m1_d_bits_param  = s_d_bits_param;
  assign m1_d_bits_size   = s_d_bits_size;
  assign m1_d_bits_source = src_q;
  assign m1_d_bits_sink   = s_d_bits_sink;
  assign m1_d_bits_data   = s_d_bits_data;
  assign m1_d_bits_error  = s_d_bits_error;

  assign a_fire = s_a_valid & s_a_ready;
  assign d_fire = s_d_valid & s_d_ready;
  assign busy   = (state_q != IDLE);
  assign owner  = owner_q;

  // Transaction sequencing and beat counting.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    owner_d      = owner_q;
    opcode_d     = opcode_q;
    size_d       = size_q;
    src_d        = src_q;
    a_cnt_d      = a_cnt_q;
    d_cnt_d      = d_cnt_q;
    case (state_q)
      IDLE: begin
        if (a_fire) begin
          owner_d      = sel;
          last_grant_d = sel;
          opcode_d     = s_a_bits_opcode;
          size_d       = s_a_bits_size;
          src_d        = sel_src;
          if (a_beats(s_a_bits_opcode, s_a_bits_size) > 9'd1) begin
            state_d = A_BURST;
            a_cnt_d = 9'd1;
          end else begin
            state_d = D_WAIT;
          end
        end
      end
      A_BURST: begin
        if (a_fire) begin
          if (a_cnt_q + 9'd1 == a_beats(opcode_q, size_q)) begin
            state_d = D_WAIT;
            a_cnt_d = 9'd0;
          end else begin
            a_cnt_d = a_cnt_q + 9'd1;
          end
        end
      end
      D_WAIT: begin
        if (d_fire) begin
          if (d_cnt_q + 9'd1 == d_beats(opcode_q, size_q)) begin
            state_d = IDLE;
            d_cnt_d = 9'd0;
          end else begin
            d_cnt_d = d_cnt_q + 9'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers; reset abandons any transaction in flight.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      owner_q      <= 1'b0;
      opcode_q     <= 3'd0;
      size_q       <= 4'd0;
      src_q        <= 1'b0;
      a_cnt_q      <= 9'd0;
      d_cnt_q      <= 9'd0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      owner_q      <= owner_d;
      opcode_q     <= opcode_d;
      size_q       <= size_d;
      src_q        <= src_d;
      a_cnt_q      <= a_cnt_d;
      d_cnt_q      <= d_cnt_d;
    end
  end

endmodule

// File: tb/tb_tilelink_ad_arbiter.sv
// Randomized bench for tilelink_ad_arbiter: two random masters, a random downstream
// slave, and a transaction-level model of grant order and beat counts.
module tb_tilelink_ad_arbiter;
  localparam int XLEN = 32;
  localparam int BB   = XLEN / 8;
  localparam int CYCLES = 4000;

  logic clock, reset;
  logic m0_a_valid, m0_a_ready, m0_a_bits_source, m0_d_ready, m0_d_valid;
  logic [2:0] m0_a_bits_opcode, m0_a_bits_param;
  logic [3:0] m0_a_bits_size;
  logic [31:0] m0_a_bits_address;
  logic [BB-1:0] m0_a_bits_mask;
  logic [XLEN-1:0] m0_a_bits_data, m0_d_bits_data;
  logic [2:0] m0_d_bits_opcode;
  logic [1:0] m0_d_bits_param;
  logic [3:0] m0_d_bits_size;
  logic m0_d_bits_source, m0_d_bits_sink, m0_d_bits_error;
  logic m1_a_valid, m1_a_ready, m1_a_bits_source, m1_d_ready, m1_d_valid;
  logic [2:0] m1_a_bits_opcode, m1_a_bits_param;
  logic [3:0] m1_a_bits_size;
  logic [31:0] m1_a_bits_address;
  logic [BB-1:0] m1_a_bits_mask;
  logic [XLEN-1:0] m1_a_bits_data, m1_d_bits_data;
  logic [2:0] m1_d_bits_opcode;
  logic [1:0] m1_d_bits_param;
  logic [3:0] m1_d_bits_size;
  logic m1_d_bits_source, m1_d_bits_sink, m1_d_bits_error;
  logic s_a_valid, s_a_ready, s_a_bits_source;
  logic [2:0] s_a_bits_opcode, s_a_bits_param;
  logic [3:0] s_a_bits_size;
  logic [31:0] s_a_bits_address;
  logic [BB-1:0] s_a_bits_mask;
  logic [XLEN-1:0] s_a_bits_data, s_d_bits_data;
  logic s_d_valid, s_d_ready, s_d_bits_source, s_d_bits_sink, s_d_bits_error;
  logic [2:0] s_d_bits_opcode;
  logic [1:0] s_d_bits_param;
  logic [3:0] s_d_bits_size;
  logic busy, owner;

  tilelink_ad_arbiter #(.XLEN(XLEN)) dut (
    .clock(clock), .reset(reset),
    .m0_a_valid(m0_a_valid), .m0_a_ready(m0_a_ready), .m0_a_bits_opcode(m0_a_bits_opcode),
    .m0_a_bits_param(m0_a_bits_param), .m0_a_bits_size(m0_a_bits_size),
    .m0_a_bits_source(m0_a_bits_source), .m0_a_bits_address(m0_a_bits_address),
    .m0_a_bits_mask(m0_a_bits_mask), .m0_a_bits_data(m0_a_bits_data),
    .m0_d_ready(m0_d_ready), .m0_d_valid(m0_d_valid), .m0_d_bits_opcode(m0_d_bits_opcode),
    .m0_d_bits_param(m0_d_bits_param), .m0_d_bits_size(m0_d_bits_size),
    .m0_d_bits_source(m0_d_bits_source), .m0_d_bits_sink(m0_d_bits_sink),
    .m0_d_bits_data(m0_d_bits_data), .m0_d_bits_error(m0_d_bits_error),
    .m1_a_valid(m1_a_valid), .m1_a_ready(m1_a_ready), .m1_a_bits_opcode(m1_a_bits_opcode),
    .m1_a_bits_param(m1_a_bits_param), .m1_a_bits_size(m1_a_bits_size),
    .m1_a_bits_source(m1_a_bits_source), .m1_a_bits_address(m1_a_bits_address),
    .m1_a_bits_mask(m1_a_bits_mask), .m1_a_bits_data(m1_a_bits_data),
    .m1_d_ready(m1_d_ready), .m1_d_valid(m1_d_valid), .m1_d_bits_opcode(m1_d_bits_opcode),
    .m1_d_bits_param(m1_d_bits_param), .m1_d_bits_size(m1_d_bits_size),
    .m1_d_bits_source(m1_d_bits_source), .m1_d_bits_sink(m1_d_bits_sink),
    .m1_d_bits_data(m1_d_bits_data), .m1_d_bits_error(m1_d_bits_error),
    .s_a_valid(s_a_valid), .s_a_ready(s_a_ready), .s_a_bits_opcode(s_a_bits_opcode),
    .s_a_bits_param(s_a_bits_param), .s_a_bits_size(s_a_bits_size),
    .s_a_bits_source(s_a_bits_source), .s_a_bits_address(s_a_bits_address),
    .s_a_bits_mask(s_a_bits_mask), .s_a_bits_data(s_a_bits_data),
    .s_d_valid(s_d_valid), .s_d_ready(s_d_ready), .s_d_bits_opcode(s_d_bits_opcode),
    .s_d_bits_param(s_d_bits_param), .s_d_bits_size(s_d_bits_size),
    .s_d_bits_source(s_d_bits_source), .s_d_bits_sink(s_d_bits_sink),
    .s_d_bits_data(s_d_bits_data), .s_d_bits_error(s_d_bits_error),
    .busy(busy), .owner(owner)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: per-master pending transaction plus a single downstream slot.
  bit          pend[2];
  int          a_left[2];
  logic [2:0]  op[2];
  logic [3:0]  sz[2];
  logic        src[2];
  logic [2:0]  prm[2];
  logic [31:0] addr[2];
  logic [BB-1:0] msk[2];
  logic [XLEN-1:0] dat[2];
  logic        av[2];
  logic        drdy[2];
  int  exp_last  = 1;
  int  exp_owner = 0;
  bit  active    = 0;
  bit  in_d      = 0;
  int  d_rem     = 0;
  int  done_cnt  = 0;

  function automatic int span(input int size);
    int s, n;
    s = (size > 8) ? 8 : size;
    n = (1 << s) / BB;
    return (n < 1) ? 1 : n;
  endfunction

  function automatic int a_total(input int o, input int s);
    return (o <= 1) ? span(s) : 1;
  endfunction

  function automatic int d_total(input int o, input int s);
    return (o == 2 || o == 3 || o == 4) ? span(s) : 1;
  endfunction

  task automatic apply_inputs();
    m0_a_valid = av[0]; m0_a_bits_opcode = op[0]; m0_a_bits_param = prm[0];
    m0_a_bits_size = sz[0]; m0_a_bits_source = src[0]; m0_a_bits_address = addr[0];
    m0_a_bits_mask = msk[0]; m0_a_bits_data = dat[0]; m0_d_ready = drdy[0];
    m1_a_valid = av[1]; m1_a_bits_opcode = op[1]; m1_a_bits_param = prm[1];
    m1_a_bits_size = sz[1]; m1_a_bits_source = src[1]; m1_a_bits_address = addr[1];
    m1_a_bits_mask = msk[1]; m1_a_bits_data = dat[1]; m1_d_ready = drdy[1];
  endtask

  task automatic drive();
    int ops[6] = '{0, 1, 2, 3, 4, 5};
    for (int i = 0; i < 2; i++) begin
      if (!pend[i] && ($urandom % 3 == 0)) begin
        pend[i]   = 1;
        op[i]     = 3'(ops[$urandom % 6]);
        sz[i]     = ($urandom % 12 == 0) ? 4'(9 + $urandom % 2) : 4'($urandom % 6);
        src[i]    = 1'($urandom);
        a_left[i] = a_total(int'(op[i]), int'(sz[i]));
      end
      av[i]   = pend[i] && (a_left[i] > 0) && ($urandom % 5 != 0);
      prm[i]  = 3'($urandom);
      addr[i] = $urandom;
      msk[i]  = BB'($urandom);
      dat[i]  = XLEN'($urandom);
      drdy[i] = ($urandom % 10 < 7);
    end
    apply_inputs();
    s_a_ready       = ($urandom % 4 != 0);
    s_d_valid       = ($urandom % 3 != 0);
    s_d_bits_opcode = 3'($urandom);
    s_d_bits_param  = 2'($urandom);
    s_d_bits_size   = 4'($urandom);
    s_d_bits_source = 1'($urandom);
    s_d_bits_sink   = 1'($urandom);
    s_d_bits_data   = XLEN'($urandom);
    s_d_bits_error  = 1'($urandom);
  endtask

  task automatic check_cycle();
    logic [1:0] r, dv;
    int w, o;
    logic [XLEN-1:0] od_data;
    logic od_src, od_err, od_sink;
    logic [2:0] od_op;
    r  = {m1_a_ready, m0_a_ready};
    dv = {m1_d_valid, m0_d_valid};
    check_eq("owner", owner, exp_owner);
    if (!active) begin
      check_eq("idle_busy", busy, 0);
      check_eq("idle_s_d_ready", s_d_ready, 0);
      check_eq("idle_d_valid", dv, 0);
      check_eq("idle_s_a_valid", s_a_valid, av[0] | av[1]);
      if (av[0] || av[1]) begin
        w = (av[0] && av[1]) ? 1 - exp_last : (av[1] ? 1 : 0);
        check_eq("grant_source", s_a_bits_source, w);
        check_eq("grant_opcode", s_a_bits_opcode, op[w]);
        check_eq("grant_size", s_a_bits_size, sz[w]);
        check_eq("grant_param", s_a_bits_param, prm[w]);
        check_eq("grant_addr", s_a_bits_address, addr[w]);
        check_eq("grant_mask", s_a_bits_mask, msk[w]);
        check_eq("grant_data", s_a_bits_data, dat[w]);
        check_eq("winner_ready", r[w], s_a_ready);
        check_eq("loser_ready", r[1-w], 0);
        if (s_a_ready) begin
          exp_last  = w;
          exp_owner = w;
          active    = 1;
          a_left[w]--;
          in_d      = (a_left[w] == 0);
          d_rem     = d_total(int'(op[w]), int'(sz[w]));
        end
      end else begin
        check_eq("idle_no_req_ready", r, 0);
      end
    end else if (!in_d) begin
      o = exp_owner;
      check_eq("burst_busy", busy, 1);
      check_eq("burst_s_d_ready", s_d_ready, 0);
      check_eq("burst_d_valid", dv, 0);
      check_eq("burst_s_a_valid", s_a_valid, av[o]);
      check_eq("burst_other_ready", r[1-o], 0);
      if (av[o]) begin
        check_eq("burst_source", s_a_bits_source, o);
        check_eq("burst_data", s_a_bits_data, dat[o]);
        check_eq("burst_addr", s_a_bits_address, addr[o]);
        check_eq("burst_ready", r[o], s_a_ready);
        if (s_a_ready) begin
          a_left[o]--;
          if (a_left[o] == 0) in_d = 1;
        end
      end
    end else begin
      o = exp_owner;
      check_eq("dwait_busy", busy, 1);
      check_eq("dwait_s_a_valid", s_a_valid, 0);
      check_eq("dwait_a_ready", r, 0);
      check_eq("dwait_other_d_valid", dv[1-o], 0);
      check_eq("dwait_owner_d_valid", dv[o], s_d_valid);
      check_eq("dwait_s_d_ready", s_d_ready, drdy[o]);
      if (s_d_valid) begin
        od_data = o ? m1_d_bits_data : m0_d_bits_data;
        od_src  = o ? m1_d_bits_source : m0_d_bits_source;
        od_err  = o ? m1_d_bits_error : m0_d_bits_error;
        od_sink = o ? m1_d_bits_sink : m0_d_bits_sink;
        od_op   = o ? m1_d_bits_opcode : m0_d_bits_opcode;
        check_eq("d_data", od_data, s_d_bits_data);
        check_eq("d_source", od_src, src[o]);
        check_eq("d_error", od_err, s_d_bits_error);
        check_eq("d_sink", od_sink, s_d_bits_sink);
        check_eq("d_opcode", od_op, s_d_bits_opcode);
        if (drdy[o]) begin
          d_rem--;
          if (d_rem == 0) begin
            active  = 0;
            in_d    = 0;
            pend[o] = 0;
            done_cnt++;
          end
        end
      end
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_s_a_valid"}, s_a_valid, 0);
    check_eq({tag, "_a_ready"}, {m1_a_ready, m0_a_ready}, 0);
    check_eq({tag, "_d_valid"}, {m1_d_valid, m0_d_valid}, 0);
    check_eq({tag, "_s_d_ready"}, s_d_ready, 0);
    check_eq({tag, "_busy"}, busy, 0);
    check_eq({tag, "_owner"}, owner, 0);
  endtask

  task automatic quiet_and_release();
    av[0] = 0; av[1] = 0;
    apply_inputs();
    s_d_valid = 0;
    reset = 1'b1;
  endtask

  initial begin
    bit did_rst;
    did_rst = 0;
    for (int i = 0; i < 2; i++) begin
      pend[i] = 0; a_left[i] = 0; op[i] = 0; sz[i] = 0; src[i] = 0; prm[i] = 0;
      addr[i] = 0; msk[i] = 0; dat[i] = 0; av[i] = 0; drdy[i] = 0;
    end
    apply_inputs();
    s_a_ready = 0; s_d_valid = 0; s_d_bits_opcode = 0; s_d_bits_param = 0;
    s_d_bits_size = 0; s_d_bits_source = 0; s_d_bits_sink = 0; s_d_bits_data = 0;
    s_d_bits_error = 0;
    reset = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    // Requests and a downstream beat asserted while reset is held must stay invisible.
    av[0] = 1; av[1] = 1; drdy[0] = 1; drdy[1] = 1;
    apply_inputs();
    s_a_ready = 1; s_d_valid = 1;
    #1;
    check_reset_outputs("in_reset");
    quiet_and_release();

    for (int cyc = 0; cyc < CYCLES; cyc++) begin
      @(negedge clock);
      drive();
      #2;
      check_cycle();
      if (!did_rst && cyc >= CYCLES / 2 && active && in_d) begin
        // Abandon an in-flight response: outputs must drop without waiting for an edge.
        did_rst = 1;
        av[0] = 1; av[1] = 1; drdy[0] = 1; drdy[1] = 1;
        apply_inputs();
        s_a_ready = 1; s_d_valid = 1;
        reset = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        @(negedge clock);
        for (int i = 0; i < 2; i++) begin
          pend[i] = 0; a_left[i] = 0;
        end
        exp_last = 1; exp_owner = 0; active = 0; in_d = 0; d_rem = 0;
        quiet_and_release();
      end
    end
    check_eq("reset_mid_txn_reached", did_rst, 1);
    check_eq("enough_txns", (done_cnt >= 20), 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tilelink_ad_arbiter.md
TILELINK_AD_ARBITER -- requirements
Module: tilelink_ad_arbiter

Interface
REQ-001 Parameter XLEN, default 32, data width; legal values 32 and 64.
REQ-002 Parameter BEAT_BYTES, default XLEN/8, bytes per beat; not overridden.
REQ-003 clock  in  1  sole clock; all state updates on the rising edge.
REQ-004 reset  in  1  asynchronous, active-low reset.
REQ-005 mN_a_valid (N=0,1)  in  1  master N A-channel request.
REQ-006 mN_a_ready  out  1  master N A accepted.
REQ-007 mN_a_bits_{opcode,param,size,source,address,mask,data}  in  3,3,4,1,32,BEAT_BYTES,XLEN  master N A fields.
REQ-008 mN_d_ready  in  1  master N accepts D.
REQ-009 mN_d_valid  out  1  D beat for master N.
REQ-010 mN_d_bits_{opcode,param,size,source,sink,data,error}  out  3,2,4,1,1,XLEN,1  D fields to master N.
REQ-011 s_a_valid, s_a_bits_{opcode,param,size,source,address,mask,data}  out  1,3,3,4,1,32,BEAT_BYTES,XLEN  shared downstream A.
REQ-012 s_a_ready  in  1  downstream A accepted.
REQ-013 s_d_valid, s_d_bits_{opcode,param,size,source,sink,data,error}  in  1,3,2,4,1,1,XLEN,1  shared downstream D.
REQ-014 s_d_ready  out  1  D accepted from downstream.
REQ-015 busy  out  1  transaction in flight (state != IDLE).
REQ-016 owner  out  1  index of current/last granted master.

Function
REQ-017 FSM states SHALL be IDLE, A_BURST, D_WAIT; exactly one transaction outstanding downstream.
REQ-018 IDLE: winner = requesting master; both requesting -> master != last_grant (round-robin); last_grant resets to 1, so master 0 wins first tie.
REQ-019 IDLE: s_a_* = winner's A fields combinationally, except s_a_bits_source = winner index; winner's a_ready = s_a_ready; loser's a_ready = 0.
REQ-020 IDLE, no request: s_a_valid = 0, both mN_a_ready = 0.
REQ-021 On s_a fire in IDLE: latch owner, opcode, size, master source; last_grant <= owner.
REQ-022 a_beats = Put (opcode 0/1) with (1<<size) > BEAT_BYTES ? (1<<size)/BEAT_BYTES : 1; multi-beat Put -> A_BURST with A counter = 1, else -> D_WAIT.
REQ-023 A_BURST: only owner forwarded (s_a_bits_source = owner); non-owner a_ready = 0; on final A beat fire -> D_WAIT.
REQ-024 d_beats = Get/Arithmetic/Logical (4/2/3) ? max(1,(1<<size)/BEAT_BYTES) : 1.
REQ-025 D_WAIT: s_d_* routed to owner; owner d_valid = s_d_valid; s_d_ready = owner d_ready; non-owner d_valid = 0; mN_d_bits_source = latched master source.
REQ-026 D beat counter increments per D fire; final beat fire -> IDLE, counter cleared.
REQ-027 No new A accepted in the cycle of final D fire; one-cycle IDLE bubble minimum between transactions.
REQ-028 s_d_valid outside D_WAIT SHALL be ignored (s_d_ready = 0, no master d_valid).
REQ-029 Beat counters 9 bits; size > 8 treated as size 8 (no wrap).
REQ-030 Master withdrawing a_valid in IDLE before fire SHALL NOT change last_grant.
REQ-031 d_bits_error passes through unmodified; error does not shorten the D burst.

Reset
REQ-032 reset low SHALL immediately (asynchronously) force state IDLE, counters 0, last_grant 1, owner 0, latched fields 0.
REQ-033 While reset low: all mN_a_ready, mN_d_valid, s_a_valid, s_d_ready, busy = 0.
REQ-034 Reset mid-transaction abandons it; no D beat forwarded after release until new grant.
REQ-035 First grant possible in first clock edge after reset high.

Verification
REQ-036 Both masters Get size 2 (XLEN=32) same cycle after reset -> m0 granted, s_a_bits_source=0; 1 D beat to m0; m1 granted next IDLE, source=1.
REQ-037 m0 Get size 4 (16B), XLEN=32 -> 4 D beats to m0 only; busy high until 4th fire; m1 a_ready=0 throughout.
REQ-038 m1 PutFull size 3, XLEN=32 -> 2 A beats (A_BURST), 1 AccessAck to m1; m0 a_ready=0 throughout.
REQ-039 m0 d_ready held low 3 cycles in D_WAIT -> s_d_ready low 3 cycles, counter stalls, no beat lost.
REQ-040 reset low during 2nd of 4 D beats -> outputs zero immediately; after release, stray s_d_valid ignored; next m0 Get granted normally.
REQ-041 Continuous requests on both masters for 8 transactions -> grants strictly alternate 0,1,0,1...
